// File: rtl/uart_msg_tx_if.sv
// uart_msg_tx_if: host write/start handshake and serial line bundle for uart_msg_tx
interface uart_msg_tx_if #(
  parameter int DATA_BITS = 8,
  parameter int MSG_DEPTH = 16
);
  logic                           wr_en;
  logic [$clog2(MSG_DEPTH)-1:0]   wr_addr;
  logic [DATA_BITS-1:0]           wr_data;
  logic [$clog2(MSG_DEPTH+1)-1:0] msg_len;
  logic                           start;
  logic                           abort;
  logic                           tx;
  logic                           busy;
  logic                           char_done;
  logic                           done;
  modport master (output wr_en, wr_addr, wr_data, msg_len, start, abort,
                  input  tx, busy, char_done, done);
  modport slave  (input  wr_en, wr_addr, wr_data, msg_len, start, abort,
                  output tx, busy, char_done, done);
endinterface

// File: rtl/uart_msg_tx.sv
// uart_msg_tx: buffered UART message transmitter with busy/done/abort handshake
module uart_msg_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int MSG_DEPTH    = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input logic clk,
  input logic jreset,
  uart_msg_tx_if.slave u
);
  localparam int AW = $clog2(MSG_DEPTH);
  localparam int LW = $clog2(MSG_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BLAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_DB = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_SB = 3'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [2:0]           bit_q, bit_d;
  logic [AW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        len_q, len_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d, busy_q, busy_d, cd_q, cd_d, done_q, done_d;
  logic                 fin, wrap, nxt, we;
  logic [DATA_BITS-1:0] ch0, rd;
  logic [DATA_BITS-1:0] mem [MSG_DEPTH];
  assign we   = u.wr_en && !busy_q;
  assign wrap = baud_q == BLAST;
  assign nxt  = LW'(idx_q) + LW'(1) < len_q;
  assign ch0  = (we && u.wr_addr == '0) ? u.wr_data : mem[0];
  assign rd   = mem[idx_q + AW'(1)];
  // character buffer: host writes only while idle, never reset
  always_ff @(posedge clk) begin
    if (we) mem[u.wr_addr] <= u.wr_data;
  end
  // state, datapath and registered outputs
  always_ff @(posedge clk or posedge jreset) begin
    if (jreset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      cd_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      cd_q    <= cd_d;
      done_q  <= done_d;
    end
  end
  // next-state: bit sequencing, character fetch at each START entry, abort override
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || wrap) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    idx_d   = idx_q;
    len_d   = len_q;
    sh_d    = sh_q;
    par_d   = par_q;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (u.start && u.msg_len != '0) begin
        state_d = START;
        len_d   = u.msg_len > LW'(MSG_DEPTH) ? LW'(MSG_DEPTH) : u.msg_len;
        idx_d   = '0;
        sh_d    = ch0;
        par_d   = ^ch0 ^ 1'(PARITY_ODD);
      end
      START: if (wrap) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (wrap) begin
        sh_d    = sh_q >> 1;
        bit_d   = bit_q == LAST_DB ? 3'd0 : bit_q + 3'd1;
        state_d = bit_q != LAST_DB ? DATA : PARITY_EN != 0 ? PARITY : STOP;
      end
      PARITY: if (wrap) begin
        state_d = STOP;
        bit_d   = '0;
      end
      STOP: if (wrap) begin
        bit_d = bit_q == LAST_SB ? 3'd0 : bit_q + 3'd1;
        if (bit_q == LAST_SB) begin
          fin     = 1'b1;
          state_d = nxt ? START : IDLE;
          if (nxt) begin
            idx_d = idx_q + AW'(1);
            sh_d  = rd;
            par_d = ^rd ^ 1'(PARITY_ODD);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (u.abort && state_q != IDLE) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      fin     = 1'b0;
    end
  end
  // outputs decoded from the upcoming state so they register in step with it
  always_comb begin
    tx_d   = state_d == START ? 1'b0 : state_d == DATA ? sh_d[0] : state_d == PARITY ? par_d : 1'b1;
    busy_d = state_d != IDLE;
    cd_d   = fin;
    done_d = fin && state_d == IDLE;
  end
  assign u.tx        = tx_q;
  assign u.busy      = busy_q;
  assign u.char_done = cd_q;
  assign u.done      = done_q;
endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: randomized frame-level check of three uart_msg_tx configurations
module tb_uart_msg_tx;
  logic clk = 1'b0, jreset = 1'b1;
  logic wr_en = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic [4:0] msg_len = '0;
  int n_tests = 0, n_fail = 0, sel = 0;
  int cpb[3] = '{4, 3, 4};
  int db[3]  = '{8, 7, 8};
  int pe[3]  = '{0, 1, 1};
  int po[3]  = '{0, 1, 0};
  int sb[3]  = '{1, 2, 2};
  logic [7:0] mdl [16];
  logic tx_m, busy_m, cd_m, done_m;
  always #5 clk = ~clk;
  uart_msg_tx_if #(.DATA_BITS(8), .MSG_DEPTH(16)) i0 ();
  uart_msg_tx_if #(.DATA_BITS(7), .MSG_DEPTH(16)) i1 ();
  uart_msg_tx_if #(.DATA_BITS(8), .MSG_DEPTH(16)) i2 ();
  assign i0.wr_en = wr_en;   assign i1.wr_en = wr_en;   assign i2.wr_en = wr_en;
  assign i0.wr_addr = wr_addr; assign i1.wr_addr = wr_addr; assign i2.wr_addr = wr_addr;
  assign i0.wr_data = wr_data; assign i1.wr_data = wr_data[6:0]; assign i2.wr_data = wr_data;
  assign i0.msg_len = msg_len; assign i1.msg_len = msg_len; assign i2.msg_len = msg_len;
  assign i0.start = start && sel == 0; assign i1.start = start && sel == 1; assign i2.start = start && sel == 2;
  assign i0.abort = abort;   assign i1.abort = abort;   assign i2.abort = abort;
  assign tx_m   = sel == 0 ? i0.tx : sel == 1 ? i1.tx : i2.tx;
  assign busy_m = sel == 0 ? i0.busy : sel == 1 ? i1.busy : i2.busy;
  assign cd_m   = sel == 0 ? i0.char_done : sel == 1 ? i1.char_done : i2.char_done;
  assign done_m = sel == 0 ? i0.done : sel == 1 ? i1.done : i2.done;
  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .MSG_DEPTH(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    d0 (.clk(clk), .jreset(jreset), .u(i0));
  uart_msg_tx #(.CLKS_PER_BIT(3), .DATA_BITS(7), .MSG_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    d1 (.clk(clk), .jreset(jreset), .u(i1));
  uart_msg_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .MSG_DEPTH(16), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2))
    d2 (.clk(clk), .jreset(jreset), .u(i2));
  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got {tx,busy,cd,done}=%b want %b", tag, got, exp);
    end
  endtask
  function automatic logic fbit(input logic [7:0] c, input int b);
    logic [7:0] m;
    m = c & 8'((1 << db[sel]) - 1);
    if (b == 0) return 1'b0;
    if (b <= db[sel]) return m[b-1];
    if (pe[sel] != 0 && b == db[sel] + 1) return 1'(($countones(m) + po[sel]) % 2);
    return 1'b1;
  endfunction
  task automatic wr(input int a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    mdl[a] = d;
  endtask
  task automatic fill();
    for (int a = 0; a < 16; a++) wr(a, 8'($urandom));
  endtask
  task automatic run(input int len, input int kill, input int kill_at);
    int L, fc, n, inj;
    logic [3:0] e;
    L  = len > 16 ? 16 : len;
    fc = (1 + db[sel] + pe[sel] + sb[sel]) * cpb[sel];
    n  = L * fc;
    inj = n > 0 ? $urandom_range(n - 1, 0) : -1;
    if ($urandom_range(1, 0) == 1) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'($urandom); mdl[0] = wr_data;
    end
    start = 1'b1; msg_len = 5'(len);
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    for (int j = 0; j <= n + 2; j++) begin
      if (L == 0) e = 4'b1000;
      else if (j < n) e = {fbit(mdl[j / fc], (j % fc) / cpb[sel]), 1'b1, (j % fc == 0 && j > 0), 1'b0};
      else if (j == n) e = 4'b1011;
      else e = 4'b1000;
      check($sformatf("s%0d len%0d c%0d", sel, len, j), {tx_m, busy_m, cd_m, done_m}, e);
      if (kill != 0 && j == kill_at) begin
        if (kill == 1) begin
          abort = 1'b1;
          @(posedge clk); #1;
          abort = 1'b0;
        end else begin
          jreset = 1'b1; #1;
          check($sformatf("s%0d rst_imm", sel), {tx_m, busy_m, cd_m, done_m}, 4'b1000);
          @(posedge clk); #1;
          jreset = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
          check($sformatf("s%0d kill%0d k%0d", sel, kill, k), {tx_m, busy_m, cd_m, done_m}, 4'b1000);
          @(posedge clk); #1;
        end
        return;
      end
      if (j == inj) begin
        start = 1'b1; msg_len = 5'($urandom_range(16, 1));
        wr_en = 1'b1; wr_addr = 4'($urandom); wr_data = 8'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0; wr_en = 1'b0;
    end
  endtask
  initial begin
    #12;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      check($sformatf("s%0d reset", s), {tx_m, busy_m, cd_m, done_m}, 4'b1000);
    end
    @(posedge clk); #1;
    jreset = 1'b0;
    sel = 0;
    fill();
    wr(0, 8'h46);
    run(1, 0, 0);
    wr(0, 8'h46); wr(1, 8'h49); wr(2, 8'h4D); wr(3, 8'h2D);
    run(4, 0, 0);
    run(0, 0, 0);
    run(31, 0, 0);
    run(4, 1, 40 + 20);
    run(4, 0, 0);
    run(3, 2, 40 + 13);
    run(2, 0, 0);
    for (int r = 0; r < 5; r++) begin
      fill();
      run($urandom_range(16, 1), 0, 0);
    end
    for (int s = 1; s < 3; s++) begin
      sel = s;
      wr(0, 8'h55);
      run(1, 0, 0);
      for (int r = 0; r < 3; r++) begin
        fill();
        run($urandom_range(6, 1), 0, 0);
      end
      run(3, 1, $urandom_range(40, 5));
      run(16, 0, 0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
